// File: rtl/rsa_pkg.sv
// Shared RSA datapath constants and the Montgomery multiplier state encoding.
// Also used by pre_processing and the exponentiation controller.
package rsa_pkg;

    localparam int RSA_WIDTH = 256;
    localparam int RSA_CNT_W = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } mont_state_e;

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: m_next = (m + a_bit*b [+ n]) / 2.
// Purely combinational so a radix-4 step can replace it later.
module mont_step #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH+1:0] m,
    input  logic             a_bit,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH+1:0] m_next
);

    logic [WIDTH+2:0] q_add;
    logic [WIDTH+2:0] q_red;

    // One spare bit above the accumulator so out-of-contract operands cannot wrap.
    always_comb begin
        q_add  = {1'b0, m} + {3'b000, (a_bit ? b : {WIDTH{1'b0}})};
        q_red  = q_add[0] ? (q_add + {3'b000, n}) : q_add;
        m_next = (WIDTH + 2)'(q_red >> 1);
    end

endmodule

// File: rtl/montgomery_mult.sv
// Radix-2 sequential Montgomery multiplier: result_o = A*B*2^-WIDTH mod N.
// Define MONT_FINAL_SUB_EN to fully reduce the result below N (otherwise result_o < 2N).
module montgomery_mult
    import rsa_pkg::*;
#(
    parameter int WIDTH = RSA_WIDTH,
    parameter int CNT_W = RSA_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] N_i,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    output logic             busy,
    output logic [WIDTH-1:0] result_o,
    output logic             finish
);

    // Handshake: start is a one-cycle request honoured only in IDLE (no queueing);
    // busy is high from the cycle after acceptance through FINAL; finish pulses for
    // the single DONE cycle, when result_o is valid; result_o then holds until the
    // next accepted request reaches FINAL.

    mont_state_e      state;
    logic [WIDTH-1:0] n_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH+1:0] m_r;
    logic [WIDTH+1:0] m_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] final_val;

    // a_r is shifted right each iteration so the current multiplier bit is always a_r[0].
    mont_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .m     (m_r),
        .a_bit (a_r[0]),
        .b     (b_r),
        .n     (n_r),
        .m_next(m_next)
    );

    always_comb begin
`ifdef MONT_FINAL_SUB_EN
        final_val = (m_r >= {2'b00, n_r}) ? (m_r[WIDTH-1:0] - n_r) : m_r[WIDTH-1:0];
`else
        final_val = m_r[WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            finish   <= 1'b0;
            result_o <= '0;
            n_r      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            m_r      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_r   <= N_i;
                        a_r   <= A_i;
                        b_r   <= B_i;
                        m_r   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    m_r <= m_next;
                    a_r <= a_r >> 1;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    result_o <= final_val;
                    busy     <= 1'b0;
                    finish   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    finish <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
